// File: rtl/pattern_seq_detector.sv
// Serial pattern recogniser for a one-bit stream. It is built as a KMP automaton whose transition
// tables are derived from PATTERN at elaboration time. It also keeps a saturating count of matches.
module pattern_seq_detector #(
   parameter int             LEN     = 4,
   parameter logic [LEN-1:0] PATTERN = 4'b1011,
   parameter bit             OVERLAP = 1'b1,
   parameter int             CNT_W   = 8,
   parameter int             ST_W    = $clog2(LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat,
   output logic [ST_W-1:0]  state
);

   // The entry for progress k is the longest suffix of (prefix_k, b) that is also a pattern prefix.
   // Pattern character i, in arrival order, is PATTERN[LEN-1-i].
   function automatic logic [LEN*ST_W-1:0] buildTrans(input logic b);
      logic [LEN*ST_W-1:0] t;
      logic [16:0]         s;
      int                  best;
      bit                  ok;
      t = '0;
      for (int k = 0; k < LEN; k++) begin
         s = '0;
         for (int i = 0; i < k; i++) s[i] = PATTERN[LEN-1-i];
         s[k] = b;
         best = 0;
         for (int j = 1; j <= k + 1; j++) begin
            ok = 1'b1;
            for (int x = 0; x < j; x++)
               if (s[k+1-j+x] != PATTERN[LEN-1-x]) ok = 1'b0;
            if (ok) best = j;
         end
         t[k*ST_W +: ST_W] = ST_W'(best);
      end
      return t;
   endfunction

   function automatic int longestBorder();
      int  best;
      bit  ok;
      best = 0;
      for (int j = 1; j < LEN; j++) begin
         ok = 1'b1;
         for (int x = 0; x < j; x++)
            if (PATTERN[j-1-x] != PATTERN[LEN-1-x]) ok = 1'b0;
         if (ok) best = j;
      end
      return best;
   endfunction

   localparam logic [LEN*ST_W-1:0] TRANS0  = buildTrans(1'b0);
   localparam logic [LEN*ST_W-1:0] TRANS1  = buildTrans(1'b1);
   localparam logic [ST_W-1:0]     RESTART = OVERLAP ? ST_W'(longestBorder()) : '0;

   logic [ST_W-1:0]  state_q, state_d, nextK;
   logic             match_q, match_d;
   logic [CNT_W-1:0] matchCnt_q, matchCnt_d;
   logic             cntSat_q, cntSat_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= '0;
         match_q    <= 1'b0;
         matchCnt_q <= '0;
         cntSat_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         match_q    <= match_d;
         matchCnt_q <= matchCnt_d;
         cntSat_q   <= cntSat_d;
      end
   end

   // Clear takes precedence over a valid bit, so a bit that arrives together with clear is discarded.
   always_comb begin
      state_d    = state_q;
      match_d    = 1'b0;
      matchCnt_d = matchCnt_q;
      cntSat_d   = cntSat_q;
      nextK      = '0;
      if (clear) begin
         state_d    = '0;
         matchCnt_d = '0;
         cntSat_d   = 1'b0;
      end else if (in_valid) begin
         nextK = in_bit ? TRANS1[int'(state_q)*ST_W +: ST_W]
                        : TRANS0[int'(state_q)*ST_W +: ST_W];
         if (nextK == ST_W'(LEN)) begin
            match_d = 1'b1;
            state_d = RESTART;
            if (!(&matchCnt_q)) begin
               matchCnt_d = matchCnt_q + 1'b1;
               if (&matchCnt_d) cntSat_d = 1'b1;
            end
         end else begin
            state_d = nextK;
         end
      end
   end

   assign match     = match_q;
   assign match_cnt = matchCnt_q;
   assign cnt_sat   = cntSat_q;
   assign state     = state_q;

endmodule

// File: tb/tb_pattern_seq_detector.sv
// Directed bench for pattern_seq_detector. Four instances (overlap, non-overlap, all-zero pattern,
// 2-bit counter) share one stimulus bus, and each test checks only the instance it targets.
module tb_pattern_seq_detector;

   typedef struct {
      logic       valid;
      logic       bitv;
      logic       expMatch;
      logic [2:0] expState;
   } vecT;

   logic clk, rst, clear, in_valid, in_bit;

   logic       ovlMatch, novMatch, zerMatch, satMatch;
   logic [7:0] ovlCnt, novCnt, zerCnt;
   logic [1:0] satCnt;
   logic       ovlSat, novSat, zerSat, satSat;
   logic [2:0] ovlState, novState, zerState, satState;

   int checks = 0;
   int errors = 0;
   vecT vq[$];

   pattern_seq_detector #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) uOvl (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
      .match(ovlMatch), .match_cnt(ovlCnt), .cnt_sat(ovlSat), .state(ovlState));

   pattern_seq_detector #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) uNov (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
      .match(novMatch), .match_cnt(novCnt), .cnt_sat(novSat), .state(novState));

   pattern_seq_detector #(.LEN(4), .PATTERN(4'b0000), .OVERLAP(1'b1), .CNT_W(8)) uZer (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
      .match(zerMatch), .match_cnt(zerCnt), .cnt_sat(zerSat), .state(zerState));

   pattern_seq_detector #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) uSat (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
      .match(satMatch), .match_cnt(satCnt), .cnt_sat(satSat), .state(satState));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drives one cycle of input, then returns 1 time unit after the sampling edge.
   task automatic applyStimulus(input logic v, input logic b);
      in_valid = v;
      in_bit   = v ? b : 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic doReset();
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic addVec(input logic v, input logic b, input logic m, input logic [2:0] s);
      vecT e;
      e.valid = v; e.bitv = b; e.expMatch = m; e.expState = s;
      vq.push_back(e);
   endtask

   task automatic runQueue(input string tag, input int which);
      logic       m;
      logic [2:0] s;
      foreach (vq[i]) begin
         applyStimulus(vq[i].valid, vq[i].bitv);
         case (which)
            0:       begin m = ovlMatch; s = ovlState; end
            1:       begin m = novMatch; s = novState; end
            default: begin m = zerMatch; s = zerState; end
         endcase
         checkOutput($sformatf("%s[%0d].match", tag, i), 32'(m), 32'(vq[i].expMatch));
         checkOutput($sformatf("%s[%0d].state", tag, i), 32'(s), 32'(vq[i].expState));
      end
      vq.delete();
   endtask

   initial begin
      logic [1:0] satExp [5];
      satExp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("reset.match", 32'(ovlMatch), 0);
      checkOutput("reset.cnt",   32'(ovlCnt),   0);
      checkOutput("reset.sat",   32'(ovlSat),   0);
      checkOutput("reset.state", 32'(ovlState), 0);

      // Basic overlapping detection on 1011011.
      addVec(1,1,0,1); addVec(1,0,0,2); addVec(1,1,0,3); addVec(1,1,1,1);
      addVec(1,0,0,2); addVec(1,1,0,3); addVec(1,1,1,1);
      runQueue("basic", 0);
      checkOutput("basic.cnt", 32'(ovlCnt), 2);

      // The same stream in non-overlapping mode matches once.
      doReset();
      addVec(1,1,0,1); addVec(1,0,0,2); addVec(1,1,0,3); addVec(1,1,1,0);
      addVec(1,0,0,0); addVec(1,1,0,1); addVec(1,1,0,1);
      runQueue("nov", 1);
      checkOutput("nov.cnt", 32'(novCnt), 1);

      // Gaps of 1 to 3 idle cycles; state holds and match stays low during gaps.
      doReset();
      addVec(1,1,0,1); addVec(0,0,0,1);
      addVec(1,0,0,2); addVec(0,0,0,2); addVec(0,0,0,2);
      addVec(1,1,0,3); addVec(0,0,0,3); addVec(0,0,0,3); addVec(0,0,0,3);
      addVec(1,1,1,1); addVec(0,0,0,1);
      addVec(1,0,0,2); addVec(0,0,0,2); addVec(0,0,0,2);
      addVec(1,1,0,3);
      addVec(1,1,1,1); addVec(0,0,0,1);
      runQueue("gap", 0);
      checkOutput("gap.cnt", 32'(ovlCnt), 2);

      // All-zero pattern: match stays high for three back-to-back valid zeros.
      doReset();
      addVec(1,0,0,1); addVec(1,0,0,2); addVec(1,0,0,3);
      addVec(1,0,1,3); addVec(1,0,1,3); addVec(1,0,1,3);
      runQueue("zero", 2);
      checkOutput("zero.cnt", 32'(zerCnt), 3);

      // Saturation with a 2-bit counter across five 1011 frames.
      doReset();
      for (int f = 0; f < 5; f++) begin
         applyStimulus(1'b1, 1'b1);
         applyStimulus(1'b1, 1'b0);
         applyStimulus(1'b1, 1'b1);
         applyStimulus(1'b1, 1'b1);
         checkOutput($sformatf("sat[%0d].match", f), 32'(satMatch), 1);
         checkOutput($sformatf("sat[%0d].cnt", f),   32'(satCnt),   32'(satExp[f]));
         checkOutput($sformatf("sat[%0d].flag", f),  32'(satSat),   (f >= 2) ? 1 : 0);
      end
      clear = 1'b1;
      applyStimulus(1'b0, 1'b0);
      clear = 1'b0;
      checkOutput("satClear.cnt",   32'(satCnt),   0);
      checkOutput("satClear.flag",  32'(satSat),   0);
      checkOutput("satClear.state", 32'(satState), 0);

      // Reset in mid-pattern overrides a valid bit and discards the progress made so far.
      doReset();
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1);
      checkOutput("midRst.pre", 32'(ovlState), 3);
      rst = 1'b1;
      applyStimulus(1'b1, 1'b1);
      rst = 1'b0;
      checkOutput("midRst.state0", 32'(ovlState), 0);
      applyStimulus(1'b1, 1'b1);
      checkOutput("midRst.state", 32'(ovlState), 1);
      checkOutput("midRst.match", 32'(ovlMatch), 0);

      // Clear in mid-pattern drops the bit that arrives with it.
      doReset();
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1);
      checkOutput("midClr.pre", 32'(ovlState), 3);
      clear = 1'b1;
      applyStimulus(1'b1, 1'b1);
      clear = 1'b0;
      checkOutput("midClr.state", 32'(ovlState), 0);
      checkOutput("midClr.match", 32'(ovlMatch), 0);
      checkOutput("midClr.cnt",   32'(ovlCnt),   0);
      applyStimulus(1'b1, 1'b1);
      checkOutput("midClr.next", 32'(ovlState), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
